// File: rtl/bank_sweep_decoder_if.sv
// Command and bank-select stream bundle for bank_sweep_decoder.
// master: issues commands and consumes beats; slave: the decoder.
interface bank_sweep_decoder_if #(
    parameter int N  = 32,
    parameter int CW = 8
);
    localparam int A = $clog2(N);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [A-1:0]  cmd_addr;
    logic [CW-1:0] cmd_count;
    logic [A-1:0]  cmd_stride;
    logic [1:0]    cmd_mode;
    logic [N-1:0]  csel;
    logic          csel_valid;
    logic          csel_ready;
    logic          oor;
    logic          done;

    modport master (
        output cmd_valid, cmd_addr, cmd_count, cmd_stride, cmd_mode,
        output csel_ready,
        input  cmd_ready, csel, csel_valid, oor, done
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_count, cmd_stride, cmd_mode,
        input  csel_ready,
        output cmd_ready, csel, csel_valid, oor, done
    );
endinterface

// File: rtl/bank_sweep_decoder.sv
// Handshaked bank sweep/broadcast decoder: one command -> stream of
// registered bank-select beats. Ports: clk, rst_n, bus (slave side).
module bank_sweep_decoder #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_sweep_decoder_if.slave  bus
);
    localparam int A = $clog2(N);
    localparam logic [A:0] NW = (A+1)'(N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [A-1:0]  addr;
    logic [A-1:0]  stride;
    logic [CW-1:0] rem;
    logic          bcast;
    logic [N-1:0]  csel_q;
    logic          oor_q;
    logic          done_q;

    logic          mode_sweep;
    logic          mode_bcast;
    logic [CW-1:0] eff_count;
    logic          cmd_acc;
    logic          beat_acc;
    logic          last;
    logic [A:0]    sum;
    logic [A:0]    wrap;
    logic [A-1:0]  addr_nxt;
    logic [A-1:0]  dec_addr;
    logic          dec_bcast;
    logic [N-1:0]  dec;
    logic          dec_oor;

    assign mode_sweep = (bus.cmd_mode == 2'b01);
    assign mode_bcast = (bus.cmd_mode == 2'b10);
    // Reserved mode 11 falls through to SINGLE.
    assign eff_count  = (mode_sweep | mode_bcast) ? bus.cmd_count : CW'(1);

    assign cmd_acc  = (state == IDLE) & bus.cmd_valid;
    assign beat_acc = (state == RUN) & bus.csel_ready;
    assign last     = (rem <= CW'(1));

    // Wrap modulo N with a single conditional subtract; an out-of-range
    // start is deliberately not corrected.
    assign sum      = {1'b0, addr} + {1'b0, stride};
    assign wrap     = (sum >= NW) ? sum - NW : sum;
    assign addr_nxt = wrap[A-1:0];

    // One shared decoder: the command address on accept, the advanced
    // address while running.
    assign dec_addr  = (state == IDLE) ? bus.cmd_addr : addr_nxt;
    assign dec_bcast = (state == IDLE) ? mode_bcast : bcast;

    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++) begin
            dec[i] = dec_bcast | (dec_addr == A'(i));
        end
    end

    assign dec_oor = ~dec_bcast & ({1'b0, dec_addr} >= NW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_acc && eff_count != '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (beat_acc && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state == IDLE);
        bus.csel_valid = (state == RUN);
        bus.csel       = csel_q;
        bus.oor        = oor_q;
        bus.done       = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            stride <= '0;
            rem    <= '0;
            bcast  <= 1'b0;
            csel_q <= '0;
            oor_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cmd_acc) begin
                addr   <= bus.cmd_addr;
                stride <= bus.cmd_stride;
                bcast  <= mode_bcast;
                rem    <= eff_count;
                if (eff_count == '0) begin
                    done_q <= 1'b1;
                    csel_q <= '0;
                    oor_q  <= 1'b0;
                end else begin
                    csel_q <= dec;
                    oor_q  <= dec_oor;
                end
            end else if (beat_acc) begin
                if (last) begin
                    csel_q <= '0;
                    oor_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    rem    <= rem - CW'(1);
                    addr   <= addr_nxt;
                    csel_q <= dec;
                    oor_q  <= dec_oor;
                end
            end
        end
    end
endmodule
